cdb_arbiter: RTL
================

# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It collects completed results from the three functional units (ALU, branch unit, memory unit) and grants the single CDB broadcast slot to one unit per cycle using round-robin priority. Each unit has a one-entry holding slot, so a unit stalls only when its slot is occupied and not being granted. The registered CDB output feeds ROB writeback and reservation-station tag wakeup. A flush on branch misprediction discards all in-flight results.

## Interface
- WIDTH, 31, MSB index of result data (data is WIDTH+1 bits)
- ROB, 2, MSB index of ROB tag (tag is ROB+1 bits)
- REG, 4, MSB index of architectural destination register (REG+1 bits)
- Requester index fixed: 0 = ALU, 1 = BRANCH, 2 = MEM

- clk  in  1  system clock, rising edge
- globalReset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous misprediction flush, active-high
- reqValid  in  3  per-unit result valid
- reqReady  out  3  per-unit accept; transfer occurs when reqValid[i] && reqReady[i] at a rising edge
- reqTag  in  3*(ROB+1)  packed ROB tags; unit i occupies bits [i*(ROB+1) +: ROB+1]
- reqResult  in  3*(WIDTH+1)  packed results, same packing scheme
- reqDest  in  3*(REG+1)  packed destination registers, same packing scheme
- cdbValid  out  1  broadcast valid (registered)
- cdbGrant  out  3  one-hot source of the current broadcast (registered); 0 when idle
- cdbTag  out  ROB+1  broadcast ROB tag
- cdbResult  out  WIDTH+1  broadcast result
- cdbDest  out  REG+1  broadcast destination register

## Operation
- State:
  - three slots {slotValid, tag, result, dest}
  - rrPtr (2 bits, legal values 0..2)
  - CDB output registers
- Arbitration is combinational over slotValid only; it never looks at reqValid. Search order is rrPtr, rrPtr+1, rrPtr+2 (mod 3). The first valid slot wins, giving the winner index w.
- reqReady[i] = !flush && (!slotValid[i] || win[i]). It has no combinational dependence on reqValid.
- On each edge without flush:
  - Winner slot contents go to the cdb* registers; cdbGrant = onehot(w); cdbValid = 1.
  - Winner slot clears, unless an accept into the same slot occurs that edge. In that case the slot loads the new request and stays valid.
  - A non-winner slot loads the request on accept.
  - rrPtr = (w+1) mod 3.
  - If no slot is valid: cdbValid = 0, cdbGrant = 0, cdb data holds its last value, rrPtr unchanged.
- flush high at an edge:
  - all slotValid cleared; cdbValid = 0; cdbGrant = 0; rrPtr = 0.
  - Requests presented that cycle are dropped (reqReady is 0).
- Reset (globalReset low, asynchronous): all slotValid = 0, cdbValid = 0, cdbGrant = 0, cdbTag/cdbResult/cdbDest = 0, rrPtr = 0, effective immediately. reqReady is 0 while reset is asserted and 3'b111 after release.
- Units must hold reqValid and their payload stable until accepted.
- The arbiter does not check tags; duplicate tags pass through unchanged.

## Timing
- Latency from accept to broadcast is 1 cycle minimum. A request accepted at edge N is visible on cdb* after edge N+1 if it wins, and later if it loses.
- Throughput is one broadcast per cycle whenever any slot is valid.
- A single active unit sustains one result per cycle, because its slot is granted and refilled on the same edge.
- With all three units continuously valid, each unit gets exactly one grant per 3 cycles. Worst-case wait for a valid slot is 2 cycles, so there is no starvation.
- cdb* outputs are valid for exactly one cycle per grant. Consumers sample them on the next edge.
- Reset release takes effect at the first rising edge after globalReset goes high. No synchronizer is included; the reset source provides a clean release.

## Test plan
- Reset: assert globalReset low mid-burst with slots full → cdbValid = 0, cdbGrant = 0, reqReady = 0 immediately. After release: reqReady = 3'b111, first grant goes to ALU when all three units are valid.
- Single unit streaming: ALU presents tags 1,2,3,4 back-to-back with reqReady held high → cdbTag = 1,2,3,4 on consecutive cycles, cdbGrant = 3'b001, no bubbles.
- Contention: all three units valid continuously from reset with tags A0/B0/M0... → grant order ALU, BRANCH, MEM, ALU...; each unit's reqReady is high once every 3 cycles.
- Rotation: MEM and BRANCH valid with rrPtr = 0 → BRANCH granted first, then MEM. rrPtr ends at 0 afterwards.
- Flush: fill all slots, assert flush for 1 cycle → next cycle cdbValid = 0, no stale tag is ever broadcast, rrPtr = 0; a new ALU request after the flush broadcasts 1 cycle after accept.
- Payload integrity: BRANCH sends result 32'hDEADBEEF, dest 5'd31, tag 3'd7 → the cdb outputs carry exactly these values with cdbGrant = 3'b010.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three one-entry result slots (ALU, BRANCH, MEM) share a
// single registered CDB broadcast slot under round-robin priority, with misprediction flush.
module cdb_arbiter #(
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int REG   = 4
) (
    input  logic                   clk,
    input  logic                   globalReset,
    input  logic                   flush,
    input  logic [2:0]             reqValid,
    output logic [2:0]             reqReady,
    input  logic [3*(ROB+1)-1:0]   reqTag,
    input  logic [3*(WIDTH+1)-1:0] reqResult,
    input  logic [3*(REG+1)-1:0]   reqDest,
    output logic                   cdbValid,
    output logic [2:0]             cdbGrant,
    output logic [ROB:0]           cdbTag,
    output logic [WIDTH:0]         cdbResult,
    output logic [REG:0]           cdbDest
);

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [2:0]   r_slot_valid;
    logic [ROB:0]   r_slot_tag    [3];
    logic [WIDTH:0] r_slot_result [3];
    logic [REG:0]   r_slot_dest   [3];
    logic [1:0]   r_rr_ptr;

    logic         r_cdb_valid;
    logic [2:0]   r_cdb_grant;
    logic [ROB:0]   r_cdb_tag;
    logic [WIDTH:0] r_cdb_result;
    logic [REG:0]   r_cdb_dest;

    logic [1:0]   w_cand [3];
    logic         w_any;
    logic [1:0]   w_win_idx;
    logic [2:0]   w_win;
    logic [2:0]   w_accept;

    // Search order starting at the round-robin pointer: rr, rr+1, rr+2 (mod 3).
    assign w_cand[0] = r_rr_ptr;
    assign w_cand[1] = wrap_inc(w_cand[0]);
    assign w_cand[2] = wrap_inc(w_cand[1]);

    always_comb begin
        w_any     = 1'b0;
        w_win_idx = 2'd0;
        // Walk backwards so the earliest candidate in search order overrides later ones.
        for (int k = 2; k >= 0; k--) begin
            if (r_slot_valid[w_cand[k]]) begin
                w_any     = 1'b1;
                w_win_idx = w_cand[k];
            end
        end
    end

    assign w_win    = w_any ? (3'b001 << w_win_idx) : 3'b000;
    assign reqReady = {3{globalReset & ~flush}} & (~r_slot_valid | w_win);
    assign w_accept = reqValid & reqReady;

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_slot_valid <= 3'b000;
        end else if (flush) begin
            r_slot_valid <= 3'b000;
        end else begin
            // NOTE: non-blocking assignment keeps this a pure next-state update; the
            // grant clear and a same-edge refill of that slot resolve without ordering hazards.
            r_slot_valid <= (r_slot_valid & ~w_win) | w_accept;
        end
    end

    // NOTE: payload storage has no reset; every read is qualified by r_slot_valid,
    // so resetting it would only add reset fan-out to a wide datapath.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_accept[i]) begin
                r_slot_tag[i]    <= reqTag[i*(ROB+1) +: ROB+1];
                r_slot_result[i] <= reqResult[i*(WIDTH+1) +: WIDTH+1];
                r_slot_dest[i]   <= reqDest[i*(REG+1) +: REG+1];
            end
        end
    end

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_grant  <= 3'b000;
            r_cdb_tag    <= '0;
            r_cdb_result <= '0;
            r_cdb_dest   <= '0;
            r_rr_ptr     <= 2'd0;
        end else if (flush) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_grant  <= 3'b000;
            r_rr_ptr     <= 2'd0;
        end else if (w_any) begin
            r_cdb_valid  <= 1'b1;
            r_cdb_grant  <= w_win;
            r_cdb_tag    <= r_slot_tag[w_win_idx];
            r_cdb_result <= r_slot_result[w_win_idx];
            r_cdb_dest   <= r_slot_dest[w_win_idx];
            r_rr_ptr     <= wrap_inc(w_win_idx);
        end else begin
            // Idle: broadcast data holds, only the qualifiers drop.
            r_cdb_valid  <= 1'b0;
            r_cdb_grant  <= 3'b000;
        end
    end

    assign cdbValid  = r_cdb_valid;
    assign cdbGrant  = r_cdb_grant;
    assign cdbTag    = r_cdb_tag;
    assign cdbResult = r_cdb_result;
    assign cdbDest   = r_cdb_dest;

endmodule
